// File: rtl/satd_pixel_feeder_pkg.sv
// Shared types and constants for the SATD pixel feeder, its block buffer and the
// downstream SATD units that consume the packed rows.
package satd_pixel_feeder_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_BLK_W = 4;
    localparam int DEF_BLK_H = 4;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } feed_state_e;

    // Counter width that never collapses to zero bits for degenerate block sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Row packing: column c of a row occupies bits [c*pix_w +: pix_w], column 0 at the LSBs.
    function automatic int pix_lsb(input int col, input int pix_w);
        return col * pix_w;
    endfunction

endpackage

// File: rtl/satd_block_buf.sv
// One-block register file: single pixel-wide write port in raster order and a
// single row-wide combinational read port.
module satd_block_buf
    import satd_pixel_feeder_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int BLK_W = DEF_BLK_W,
    parameter int BLK_H = DEF_BLK_H,
    parameter int IDX_W = cnt_w(BLK_W * BLK_H),
    parameter int ROW_W = cnt_w(BLK_H)
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [PIX_W-1:0]       wr_org,
    input  logic [PIX_W-1:0]       wr_cur,
    input  logic [ROW_W-1:0]       rd_row,
    output logic [BLK_W*PIX_W-1:0] rd_org,
    output logic [BLK_W*PIX_W-1:0] rd_cur
);

    localparam int NPIX = BLK_W * BLK_H;

    logic [PIX_W-1:0] org_mem_r [NPIX];
    logic [PIX_W-1:0] cur_mem_r [NPIX];
    logic [IDX_W-1:0] rd_idx_s;

    // Pixel write port; stale contents are never observed, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            org_mem_r[wr_idx] <= wr_org;
            cur_mem_r[wr_idx] <= wr_cur;
        end
    end

    // Row read port: gather BLK_W consecutive raster entries into one packed row.
    always_comb begin
        rd_org   = '0;
        rd_cur   = '0;
        rd_idx_s = '0;
        for (int c = 0; c < BLK_W; c++) begin
            rd_idx_s = IDX_W'(int'(rd_row) * BLK_W + c);
            rd_org[pix_lsb(c, PIX_W) +: PIX_W] = org_mem_r[rd_idx_s];
            rd_cur[pix_lsb(c, PIX_W) +: PIX_W] = cur_mem_r[rd_idx_s];
        end
    end

endmodule

// File: rtl/satd_pixel_feeder.sv
// SATD producer: collects one block of org/cur pixel pairs from a byte-serial stream,
// then presents it row by row to the SATD engine over a registered valid/ready link.
module satd_pixel_feeder
    import satd_pixel_feeder_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int BLK_W = DEF_BLK_W,
    parameter int BLK_H = DEF_BLK_H
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_org,
    input  logic [PIX_W-1:0]           in_cur,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLK_W*PIX_W-1:0]     out_org,
    output logic [BLK_W*PIX_W-1:0]     out_cur,
    output logic [cnt_w(BLK_H)-1:0]    out_row,
    output logic                       out_last,
    output logic                       blk_done
);

    localparam int NPIX  = BLK_W * BLK_H;
    localparam int IDX_W = cnt_w(NPIX);
    localparam int ROW_W = cnt_w(BLK_H);
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(NPIX - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLK_H - 1);

    feed_state_e              state_r, state_s;
    logic [IDX_W-1:0]         pix_cnt_r, pix_cnt_s;
    logic [ROW_W-1:0]         row_cnt_r, row_cnt_s;
    logic                     in_fire_s, out_fire_s, done_s, load_s;
    logic [BLK_W*PIX_W-1:0]   rd_org_s, rd_cur_s;

    logic                     in_ready_r, out_valid_r, out_last_r, blk_done_r;
    logic [BLK_W*PIX_W-1:0]   out_org_r, out_cur_r;
    logic [ROW_W-1:0]         out_row_r;

    // abort masks both handshakes so a same-cycle pair or row is never consumed.
    assign in_fire_s  = in_valid && (state_r == ST_FILL) && !abort;
    assign out_fire_s = out_valid_r && out_ready && !abort;

    // The read port is addressed with the next row so the output register loads it on the same edge.
    satd_block_buf #(
        .PIX_W (PIX_W),
        .BLK_W (BLK_W),
        .BLK_H (BLK_H),
        .IDX_W (IDX_W),
        .ROW_W (ROW_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (in_fire_s),
        .wr_idx (pix_cnt_r),
        .wr_org (in_org),
        .wr_cur (in_cur),
        .rd_row (row_cnt_s),
        .rd_org (rd_org_s),
        .rd_cur (rd_cur_s)
    );

    // Next-state, counter and row-load decode.
    always_comb begin
        state_s   = state_r;
        pix_cnt_s = pix_cnt_r;
        row_cnt_s = row_cnt_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        if (abort) begin
            state_s   = ST_FILL;
            pix_cnt_s = '0;
            row_cnt_s = '0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (in_fire_s) begin
                        if (pix_cnt_r == LAST_PIX) begin
                            pix_cnt_s = '0;
                            state_s   = ST_DRAIN;
                            load_s    = 1'b1;
                        end else begin
                            pix_cnt_s = pix_cnt_r + IDX_W'(1);
                        end
                    end else begin
                        pix_cnt_s = pix_cnt_r;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_s) begin
                        if (row_cnt_r == LAST_ROW) begin
                            row_cnt_s = '0;
                            state_s   = ST_FILL;
                            done_s    = 1'b1;
                        end else begin
                            row_cnt_s = row_cnt_r + ROW_W'(1);
                            load_s    = 1'b1;
                        end
                    end else begin
                        row_cnt_s = row_cnt_r;
                    end
                end
                default: begin
                    state_s   = ST_FILL;
                    pix_cnt_s = '0;
                    row_cnt_s = '0;
                end
            endcase
        end
    end

    // State, counters and every output are registered; handshake outputs follow the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_FILL;
            pix_cnt_r   <= '0;
            row_cnt_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_row_r   <= '0;
            out_last_r  <= 1'b0;
            blk_done_r  <= 1'b0;
            out_org_r   <= '0;
            out_cur_r   <= '0;
        end else begin
            state_r     <= state_s;
            pix_cnt_r   <= pix_cnt_s;
            row_cnt_r   <= row_cnt_s;
            in_ready_r  <= (state_s == ST_FILL);
            out_valid_r <= (state_s == ST_DRAIN);
            out_row_r   <= row_cnt_s;
            out_last_r  <= (state_s == ST_DRAIN) && (row_cnt_s == LAST_ROW);
            blk_done_r  <= done_s;
            if (load_s) begin
                out_org_r <= rd_org_s;
                out_cur_r <= rd_cur_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_org   = out_org_r;
    assign out_cur   = out_cur_r;
    assign out_row   = out_row_r;
    assign out_last  = out_last_r;
    assign blk_done  = blk_done_r;

endmodule

// File: tb/tb_satd_pixel_feeder.sv
// Directed self-checking bench for satd_pixel_feeder with default 8-bit, 4x4 geometry.
module tb_satd_pixel_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_org = 8'h00;
    logic [7:0]  in_cur = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_org, out_cur;
    logic [1:0]  out_row;
    logic        out_last;
    logic        blk_done;

    int checks = 0;
    int errors = 0;

    satd_pixel_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_org    (in_org),
        .in_cur    (in_cur),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_org   (out_org),
        .out_cur   (out_cur),
        .out_row   (out_row),
        .out_last  (out_last),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Row r of a block whose pixel k is base+k, column 0 in the low byte.
    function automatic logic [31:0] exp_row(input logic [7:0] base, input int r);
        logic [31:0] v;
        v = 32'h0;
        for (int c = 0; c < 4; c++) v[c*8 +: 8] = base + 8'(4 * r + c);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stream 16 pairs base+k; with gaps, in_valid alternates 1/0.
    task automatic feed(input logic [7:0] org0, input logic [7:0] cur0, input bit gaps);
        int n = 0;
        bit tog = 1'b1;
        for (int it = 0; it < 64 && n < 16; it++) begin
            if (gaps && !tog) begin
                in_valid = 1'b0;
                in_org   = 8'hEE;
                in_cur   = 8'hEE;
            end else begin
                in_valid = 1'b1;
                in_org   = org0 + 8'(n);
                in_cur   = cur0 + 8'(n);
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready pix%0d got %b want 1", n, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_out_valid pix%0d got %b want 0", n, out_valid); end
            step();
            checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL fill_blk_done pix%0d got %b want 0", n, blk_done); end
            if (in_valid) n++;
            tog = !tog;
        end
        in_valid = 1'b0;
        checks++; if (n != 16) begin errors++; $display("FAIL feed_bound got %0d pixels want 16", n); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_entry_in_ready got %b want 0", in_ready); end
    endtask

    // Accept all four rows, optionally holding out_ready low on one row; ends in the blk_done cycle.
    task automatic drain_check(input logic [7:0] org0, input logic [7:0] cur0,
                               input int stall_row, input int stall_cycles);
        for (int r = 0; r < 4; r++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid row%0d got %b want 1", r, out_valid); end
            checks++; if (out_row !== 2'(r)) begin errors++; $display("FAIL drain_row got %0d want %0d", out_row, r); end
            checks++; if (out_last !== (r == 3)) begin errors++; $display("FAIL drain_last row%0d got %b want %b", r, out_last, (r == 3)); end
            checks++; if (out_org !== exp_row(org0, r)) begin errors++; $display("FAIL drain_org row%0d got %h want %h", r, out_org, exp_row(org0, r)); end
            checks++; if (out_cur !== exp_row(cur0, r)) begin errors++; $display("FAIL drain_cur row%0d got %h want %h", r, out_cur, exp_row(cur0, r)); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drain_in_ready row%0d got %b want 0", r, in_ready); end
            checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL drain_early_done row%0d got %b want 0", r, blk_done); end
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    step();
                    checks++; if (out_valid !== 1'b1 || out_row !== 2'(r)) begin errors++; $display("FAIL stall_hold cyc%0d got valid=%b row=%0d want 1/%0d", s, out_valid, out_row, r); end
                    checks++; if (out_org !== exp_row(org0, r) || out_cur !== exp_row(cur0, r)) begin errors++; $display("FAIL stall_data cyc%0d got %h/%h want %h/%h", s, out_org, out_cur, exp_row(org0, r), exp_row(cur0, r)); end
                    checks++; if (in_ready !== 1'b0 || blk_done !== 1'b0) begin errors++; $display("FAIL stall_ctrl cyc%0d got rdy=%b done=%b want 0/0", s, in_ready, blk_done); end
                end
                out_ready = 1'b1;
            end
            step();
        end
        checks++; if (blk_done !== 1'b1) begin errors++; $display("FAIL blk_done got %b want 1", blk_done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_drain_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_drain_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || blk_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl got v=%b l=%b d=%b want 0/0/0", out_valid, out_last, blk_done); end
        checks++; if (out_row !== 2'd0 || out_org !== 32'h0 || out_cur !== 32'h0) begin errors++; $display("FAIL reset_data got row=%0d org=%h cur=%h want 0", out_row, out_org, out_cur); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        feed(8'h00, 8'd100, 1'b0);
        checks++; if (out_org !== 32'h03020100 || out_cur !== 32'h67666564) begin errors++; $display("FAIL basic_row0 got %h/%h want 03020100/67666564", out_org, out_cur); end
        drain_check(8'h00, 8'd100, -1, 0);
        step();
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL blk_done_pulse got %b want 0", blk_done); end
    endtask

    task automatic test_backpressure();
        feed(8'h00, 8'd100, 1'b0);
        drain_check(8'h00, 8'd100, 1, 5);
        step();
    endtask

    task automatic test_gaps();
        feed(8'h00, 8'd100, 1'b1);
        drain_check(8'h00, 8'd100, -1, 0);
        step();
    endtask

    // The next block's first pair is held on the input during drain and must not be taken early.
    task automatic test_back_to_back();
        feed(8'h10, 8'h80, 1'b0);
        in_valid = 1'b1;
        in_org   = 8'hF0;
        in_cur   = 8'hC0;
        drain_check(8'h10, 8'h80, -1, 0);
        feed(8'hF0, 8'hC0, 1'b0);
        checks++; if (out_org !== 32'hF3F2F1F0) begin errors++; $display("FAIL b2b_row0 got %h want F3F2F1F0", out_org); end
        drain_check(8'hF0, 8'hC0, -1, 0);
        step();
    endtask

    task automatic test_abort();
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_org   = 8'h50 + 8'(k);
            in_cur   = 8'h60 + 8'(k);
            step();
        end
        abort    = 1'b1;
        in_org   = 8'h57;
        in_cur   = 8'h67;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_state got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        repeat (12) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL partial_output got %b want 0", out_valid); end
        feed(8'h20, 8'h30, 1'b0);
        drain_check(8'h20, 8'h30, -1, 0);
        step();
    endtask

    task automatic test_abort_last();
        feed(8'h00, 8'd100, 1'b0);
        repeat (3) step();
        checks++; if (out_row !== 2'd3 || out_last !== 1'b1) begin errors++; $display("FAIL abort_last_setup got row=%0d last=%b want 3/1", out_row, out_last); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL abort_last_done got %b want 0", blk_done); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_last_state got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        step();
        checks++; if (blk_done !== 1'b0) begin errors++; $display("FAIL abort_last_done_late got %b want 0", blk_done); end
    endtask

    task automatic test_async_reset();
        feed(8'h40, 8'h48, 1'b0);
        repeat (2) step();
        checks++; if (out_row !== 2'd2) begin errors++; $display("FAIL areset_setup got row=%0d want 2", out_row); end
        #2 reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL areset_immediate got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        checks++; if (out_row !== 2'd0 || out_org !== 32'h0) begin errors++; $display("FAIL areset_data got row=%0d org=%h want 0/0", out_row, out_org); end
        @(posedge clk);
        #1 reset = 1'b1;
        feed(8'h70, 8'h78, 1'b0);
        drain_check(8'h70, 8'h78, -1, 0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_abort();
        test_abort_last();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
